// File: rtl/rv_pkg.sv
// Shared RV core definitions used by the load/store unit: funct3 size codes,
// the LSU state encoding and the access-size helper.
package rv_pkg;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_D  = 3'd3;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;
    localparam logic [2:0] F3_WU = 3'd6;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } rv_lsu_state_t;

    // Access size in bytes; the low two funct3 bits encode log2(size).
    function automatic logic [3:0] lsu_size(input logic [2:0] funct3);
        return 4'd1 << funct3[1:0];
    endfunction

endpackage

// File: rtl/rv_lsu_align.sv
// Byte-lane steering for the LSU: store mask and lane replication, plus load
// data extraction with sign/zero extension. Purely combinational.
module rv_lsu_align
    import rv_pkg::*;
#(
    parameter  int XLEN  = 32,
    localparam int NB    = XLEN / 8,
    localparam int OFS_W = $clog2(NB)
) (
    input  logic [2:0]       funct3_i,
    input  logic [OFS_W-1:0] ofs_i,
    input  logic [XLEN-1:0]  wdata_i,
    input  logic [XLEN-1:0]  rdata_i,
    output logic [NB-1:0]    wmask_o,
    output logic [XLEN-1:0]  wdata_o,
    output logic [XLEN-1:0]  ldata_o
);

    localparam logic [3:0] NB_B = 4'(NB);

    logic [3:0]      size_b;
    logic [NB-1:0]   base_mask;
    logic [XLEN-1:0] shifted;
    logic            sign_bit;

    // Doubleword codes on a 32-bit datapath are rejected upstream; clipping
    // keeps every lane index in range for that case.
    assign size_b  = (lsu_size(funct3_i) > NB_B) ? NB_B : lsu_size(funct3_i);
    assign shifted = rdata_i >> {ofs_i, 3'b000};

    // NOTE: every output of a combinational block gets a default first, so no
    // path can leave a signal unassigned and infer a latch.
    always_comb begin
        base_mask = '0;
        for (int i = 0; i < NB; i++) begin
            base_mask[i] = (4'(i) < size_b);
        end
        wmask_o = base_mask << ofs_i;
    end

    always_comb begin
        wdata_o = wdata_i;
        case (size_b)
            4'd1:    wdata_o = {NB{wdata_i[7:0]}};
            4'd2:    wdata_o = {(NB / 2){wdata_i[15:0]}};
            4'd4:    wdata_o = {(NB / 4){wdata_i[31:0]}};
            default: wdata_o = wdata_i;
        endcase
    end

    always_comb begin
        sign_bit = 1'b0;
        case (size_b)
            4'd1:    sign_bit = shifted[7];
            4'd2:    sign_bit = shifted[15];
            4'd4:    sign_bit = shifted[31];
            default: sign_bit = shifted[XLEN-1];
        endcase
        sign_bit = sign_bit & ~funct3_i[2];
        ldata_o  = '0;
        for (int i = 0; i < XLEN; i++) begin
            ldata_o[i] = (i < 8 * int'(size_b)) ? shifted[i] : sign_bit;
        end
    end

endmodule

// File: rtl/rv_lsu.sv
// Load/store unit for the multicycle RV core: one request at a time, a single
// memory strobe per legal access, aligned and extended load response.
module rv_lsu
    import rv_pkg::*;
#(
    parameter  int XLEN   = 32,
    parameter  int ADDR_W = 32,
    localparam int NB     = XLEN / 8,
    localparam int OFS_W  = $clog2(NB)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_load_i,
    input  logic [2:0]        req_funct3_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [XLEN-1:0]   req_wdata_i,
    input  logic [4:0]        req_rd_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [XLEN-1:0]   rsp_data_o,
    output logic [4:0]        rsp_rd_o,
    output logic              rsp_err_o,
    output logic [ADDR_W-1:0] mem_d_addr_o,
    output logic [XLEN-1:0]   mem_d_wdata_o,
    output logic [NB-1:0]     mem_d_wmask_o,
    output logic              mem_d_wstrb_o,
    output logic              mem_d_rstrb_o,
    input  logic [XLEN-1:0]   mem_d_rdata_i,
    input  logic              mem_d_rbusy_i,
    input  logic              mem_d_wbusy_i
);

    rv_lsu_state_t     state_q, state_d;
    logic              load_q, load_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic [4:0]        rd_q, rd_d;
    logic              err_q, err_d;
    logic [XLEN-1:0]   data_q, data_d;

    logic [NB-1:0]     lane_mask;
    logic [XLEN-1:0]   lane_wdata;
    logic [XLEN-1:0]   lane_ldata;
    logic [OFS_W-1:0]  align_mask;
    logic              misaligned;
    logic              bad_code;
    logic              too_wide;
    logic              illegal;
    logic              mem_active;
    logic              busy;

    rv_lsu_align #(.XLEN(XLEN)) u_align (
        .funct3_i (funct3_q),
        .ofs_i    (addr_q[OFS_W-1:0]),
        .wdata_i  (wdata_q),
        .rdata_i  (mem_d_rdata_i),
        .wmask_o  (lane_mask),
        .wdata_o  (lane_wdata),
        .ldata_o  (lane_ldata)
    );

    // Legality is judged on the incoming request so a bad access skips memory.
    assign align_mask = OFS_W'(lsu_size(req_funct3_i) - 4'd1);
    assign misaligned = |(req_addr_i[OFS_W-1:0] & align_mask);
    assign bad_code   = req_load_i ? (req_funct3_i == 3'd7) : req_funct3_i[2];
    assign too_wide   = (XLEN == 32) &&
                        ((req_funct3_i == F3_D) || (req_load_i && req_funct3_i == F3_WU));
    assign illegal    = misaligned | bad_code | too_wide;

    assign busy = load_q ? mem_d_rbusy_i : mem_d_wbusy_i;

    always_comb begin
        state_d  = state_q;
        load_d   = load_q;
        funct3_d = funct3_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rd_d     = rd_q;
        err_d    = err_q;
        data_d   = data_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    load_d   = req_load_i;
                    funct3_d = req_funct3_i;
                    addr_d   = req_addr_i;
                    wdata_d  = req_wdata_i;
                    rd_d     = req_rd_i;
                    err_d    = illegal;
                    data_d   = '0;
                    state_d  = illegal ? ST_RESP : ST_ISSUE;
                end
            end
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT: begin
                if (!busy) begin
                    data_d  = load_q ? lane_ldata : '0;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            load_q   <= 1'b0;
            funct3_q <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rd_q     <= '0;
            err_q    <= 1'b0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            load_q   <= load_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rd_q     <= rd_d;
            err_q    <= err_d;
            data_q   <= data_d;
        end
    end

    // Memory-side fields are driven only while an access is outstanding.
    assign mem_active    = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
    assign mem_d_addr_o  = mem_active ? {addr_q[ADDR_W-1:OFS_W], {OFS_W{1'b0}}} : '0;
    assign mem_d_wdata_o = mem_active ? lane_wdata : '0;
    assign mem_d_wmask_o = mem_active ? lane_mask : '0;
    assign mem_d_rstrb_o = (state_q == ST_ISSUE) &&  load_q;
    assign mem_d_wstrb_o = (state_q == ST_ISSUE) && !load_q;

    assign req_ready_o = (state_q == ST_IDLE);
    assign rsp_valid_o = (state_q == ST_RESP);
    assign rsp_data_o  = data_q;
    assign rsp_rd_o    = rd_q;
    assign rsp_err_o   = err_q;

endmodule

// File: tb/tb_rv_lsu.sv
// Bench for rv_lsu: 32- and 64-bit instances share one stimulus path; a
// vector table feeds a response scoreboard, plus reset-in-flight sequences.
module tb_rv_lsu;

    logic        clk;
    logic        rst_n;
    logic        use64;
    logic        req_valid;
    logic        req_load;
    logic [2:0]  req_f3;
    logic [31:0] req_addr;
    logic [63:0] req_wdata;
    logic [4:0]  req_rd;
    logic        rsp_ready;
    logic [63:0] rdata;
    logic        rbusy;
    logic        wbusy;

    logic        ready32, valid32, err32, wstrb32, rstrb32;
    logic [31:0] data32, addr32, wdata32;
    logic [4:0]  rd32;
    logic [3:0]  mask32;
    logic        ready64, valid64, err64, wstrb64, rstrb64;
    logic [63:0] data64, wdata64;
    logic [31:0] addr64;
    logic [4:0]  rd64;
    logic [7:0]  mask64;

    rv_lsu #(.XLEN(32), .ADDR_W(32)) u_dut32 (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid & ~use64), .req_ready_o(ready32),
        .req_load_i(req_load), .req_funct3_i(req_f3), .req_addr_i(req_addr),
        .req_wdata_i(req_wdata[31:0]), .req_rd_i(req_rd),
        .rsp_valid_o(valid32), .rsp_ready_i(rsp_ready), .rsp_data_o(data32),
        .rsp_rd_o(rd32), .rsp_err_o(err32),
        .mem_d_addr_o(addr32), .mem_d_wdata_o(wdata32), .mem_d_wmask_o(mask32),
        .mem_d_wstrb_o(wstrb32), .mem_d_rstrb_o(rstrb32),
        .mem_d_rdata_i(rdata[31:0]), .mem_d_rbusy_i(rbusy), .mem_d_wbusy_i(wbusy)
    );

    rv_lsu #(.XLEN(64), .ADDR_W(32)) u_dut64 (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid & use64), .req_ready_o(ready64),
        .req_load_i(req_load), .req_funct3_i(req_f3), .req_addr_i(req_addr),
        .req_wdata_i(req_wdata), .req_rd_i(req_rd),
        .rsp_valid_o(valid64), .rsp_ready_i(rsp_ready), .rsp_data_o(data64),
        .rsp_rd_o(rd64), .rsp_err_o(err64),
        .mem_d_addr_o(addr64), .mem_d_wdata_o(wdata64), .mem_d_wmask_o(mask64),
        .mem_d_wstrb_o(wstrb64), .mem_d_rstrb_o(rstrb64),
        .mem_d_rdata_i(rdata), .mem_d_rbusy_i(rbusy), .mem_d_wbusy_i(wbusy)
    );

    // Unified view of whichever instance is selected.
    logic        req_ready, rsp_valid, rsp_err, wstrb, rstrb;
    logic [63:0] rsp_data, mem_wdata;
    logic [31:0] mem_addr;
    logic [4:0]  rsp_rd;
    logic [7:0]  mem_mask;

    assign req_ready = use64 ? ready64 : ready32;
    assign rsp_valid = use64 ? valid64 : valid32;
    assign rsp_err   = use64 ? err64 : err32;
    assign rsp_data  = use64 ? data64 : {32'h0, data32};
    assign rsp_rd    = use64 ? rd64 : rd32;
    assign wstrb     = use64 ? wstrb64 : wstrb32;
    assign rstrb     = use64 ? rstrb64 : rstrb32;
    assign mem_addr  = use64 ? addr64 : addr32;
    assign mem_wdata = use64 ? wdata64 : {32'h0, wdata32};
    assign mem_mask  = use64 ? mask64 : {4'h0, mask32};

    typedef struct {
        logic        use64;
        logic        load;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [63:0] wdata;
        logic [63:0] rdata;
        int          busy;
        int          hold;
        logic [4:0]  rd;
        logic        err;
        logic [63:0] data;
        logic [31:0] eaddr;
        logic [7:0]  emask;
        logic [63:0] ewdata;
    } vec_t;

    typedef struct {
        logic [4:0]  rd;
        logic        err;
        logic [63:0] data;
        int          cyc;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    logic seen_q = 1'b0;
    int   first_q = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: pop one expectation per accepted response.
    always @(negedge clk) begin
        int fc;
        exp_t e;
        fc = seen_q ? first_q : cyc;
        if (rsp_valid && !seen_q) begin
            seen_q  <= 1'b1;
            first_q <= cyc;
        end
        if (rsp_valid && rsp_ready) begin
            seen_q <= 1'b0;
            if (sb.size() == 0) begin
                check("unexpected response", 1'b1, 1'b0);
            end else begin
                e = sb.pop_front();
                check($sformatf("rsp_rd tag%0d", e.rd), rsp_rd, e.rd);
                check($sformatf("rsp_err tag%0d", e.rd), rsp_err, e.err);
                check($sformatf("rsp_data tag%0d", e.rd), rsp_data, e.data);
                check($sformatf("rsp latency tag%0d", e.rd), fc, e.cyc);
            end
        end
    end

    task automatic run_vec(input vec_t v);
        exp_t e;
        int   strobes;
        int   busy_left;
        logic got;
        rsp_ready = (v.hold == 0);
        @(posedge clk); #1;
        use64 = v.use64; req_load = v.load; req_f3 = v.f3; req_addr = v.addr;
        req_wdata = v.wdata; req_rd = v.rd; rdata = v.rdata;
        rbusy = 1'b0; wbusy = 1'b0; req_valid = 1'b1;
        @(negedge clk);
        check($sformatf("req_ready idle tag%0d", v.rd), req_ready, 1'b1);
        e.rd = v.rd; e.err = v.err; e.data = v.data;
        e.cyc = cyc + (v.err ? 1 : 3 + v.busy);
        sb.push_back(e);
        @(posedge clk); #1;
        req_valid = 1'b0;
        strobes = 0; busy_left = 0; got = 1'b0;
        for (int t = 0; t < 40 && !got; t++) begin
            @(negedge clk);
            if (rstrb || wstrb) begin
                strobes++;
                check($sformatf("strobe kind tag%0d", v.rd), {rstrb, wstrb}, v.load ? 2'b10 : 2'b01);
                check($sformatf("mem_addr tag%0d", v.rd), mem_addr, v.eaddr);
                check($sformatf("mem_wmask tag%0d", v.rd), mem_mask, v.emask);
                check($sformatf("mem_wdata tag%0d", v.rd), mem_wdata, v.ewdata);
                busy_left = v.busy;
            end
            if (rsp_valid) begin
                got = 1'b1;
            end else begin
                @(posedge clk); #1;
                if (v.load) rbusy = (busy_left > 0);
                else        wbusy = (busy_left > 0);
                if (busy_left > 0) busy_left--;
            end
        end
        check($sformatf("rsp arrived tag%0d", v.rd), got, 1'b1);
        check($sformatf("strobe count tag%0d", v.rd), strobes, v.err ? 0 : 1);
        for (int h = 0; h < v.hold; h++) begin
            check($sformatf("held valid tag%0d", v.rd), {rsp_valid, req_ready}, 2'b10);
            check($sformatf("held data tag%0d", v.rd), rsp_data, v.data);
            check($sformatf("held rd/err tag%0d", v.rd), {rsp_rd, rsp_err}, {v.rd, v.err});
            @(posedge clk); #1;
            if (h == v.hold - 1) rsp_ready = 1'b1;
            @(negedge clk);
        end
        @(posedge clk); #1;
        @(negedge clk);
        check($sformatf("back to idle tag%0d", v.rd), {req_ready, rsp_valid}, 2'b10);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //                 64 ld f3    addr         wdata                  rdata                  bsy hld rd  err data                   eaddr         emask  ewdata
        vecs.push_back('{0, 0, 3'd0, 32'h103, 64'hAB,                64'h0,                 0, 0, 5'd1,  0, 64'h0,                 32'h100, 8'h08, 64'hABABABAB});
        vecs.push_back('{0, 1, 3'd1, 32'h102, 64'h0,                 64'h80010000,          0, 5, 5'd2,  0, 64'hFFFF8001,          32'h100, 8'h0C, 64'h0});
        vecs.push_back('{0, 1, 3'd5, 32'h102, 64'h0,                 64'h80010000,          0, 0, 5'd3,  0, 64'h00008001,          32'h100, 8'h0C, 64'h0});
        vecs.push_back('{1, 1, 3'd3, 32'h8,   64'h0,                 64'h1122334455667788,  4, 0, 5'd4,  0, 64'h1122334455667788,  32'h8,   8'hFF, 64'h0});
        vecs.push_back('{0, 1, 3'd2, 32'h2,   64'h0,                 64'h0,                 0, 0, 5'd5,  1, 64'h0,                 32'h0,   8'h00, 64'h0});
        vecs.push_back('{0, 1, 3'd3, 32'h0,   64'h0,                 64'h0,                 0, 0, 5'd6,  1, 64'h0,                 32'h0,   8'h00, 64'h0});
        vecs.push_back('{0, 0, 3'd2, 32'h4,   64'hDEADBEEF,          64'h0,                 2, 0, 5'd7,  0, 64'h0,                 32'h4,   8'h0F, 64'hDEADBEEF});
        vecs.push_back('{1, 1, 3'd0, 32'h5,   64'h0,                 64'h00009A0000000000,  0, 0, 5'd8,  0, 64'hFFFFFFFFFFFFFF9A,  32'h0,   8'h20, 64'h0});
        vecs.push_back('{1, 1, 3'd6, 32'h4,   64'h0,                 64'h8765432100000000,  1, 0, 5'd9,  0, 64'h0000000087654321,  32'h0,   8'hF0, 64'h0});
        vecs.push_back('{1, 1, 3'd2, 32'h4,   64'h0,                 64'h8765432100000000,  0, 0, 5'd10, 0, 64'hFFFFFFFF87654321,  32'h0,   8'hF0, 64'h0});
        vecs.push_back('{1, 0, 3'd1, 32'h6,   64'h1234,              64'h0,                 0, 0, 5'd11, 0, 64'h0,                 32'h0,   8'hC0, 64'h1234123412341234});
        vecs.push_back('{1, 0, 3'd3, 32'h10,  64'h0102030405060708,  64'h0,                 1, 0, 5'd12, 0, 64'h0,                 32'h10,  8'hFF, 64'h0102030405060708});
        vecs.push_back('{0, 0, 3'd4, 32'h0,   64'h0,                 64'h0,                 0, 0, 5'd13, 1, 64'h0,                 32'h0,   8'h00, 64'h0});
        vecs.push_back('{0, 1, 3'd7, 32'h0,   64'h0,                 64'h0,                 0, 0, 5'd14, 1, 64'h0,                 32'h0,   8'h00, 64'h0});
        vecs.push_back('{1, 0, 3'd1, 32'h3,   64'h0,                 64'h0,                 0, 0, 5'd15, 1, 64'h0,                 32'h0,   8'h00, 64'h0});
        vecs.push_back('{0, 1, 3'd4, 32'h201, 64'h0,                 64'h0000F000,          0, 0, 5'd16, 0, 64'h000000F0,          32'h200, 8'h02, 64'h0});
        vecs.push_back('{0, 1, 3'd6, 32'h0,   64'h0,                 64'h0,                 0, 0, 5'd17, 1, 64'h0,                 32'h0,   8'h00, 64'h0});
        vecs.push_back('{1, 1, 3'd6, 32'h2,   64'h0,                 64'h0,                 0, 0, 5'd18, 1, 64'h0,                 32'h0,   8'h00, 64'h0});
        vecs.push_back('{1, 0, 3'd0, 32'h7,   64'hFFFFFF5A,          64'h0,                 3, 0, 5'd19, 0, 64'h0,                 32'h0,   8'h80, 64'h5A5A5A5A5A5A5A5A});

        rst_n = 1'b0; use64 = 1'b0; req_valid = 1'b0; req_load = 1'b0; req_f3 = '0;
        req_addr = '0; req_wdata = '0; req_rd = '0; rsp_ready = 1'b1; rdata = '0;
        rbusy = 1'b0; wbusy = 1'b0;
        #2;
        for (int k = 0; k < 2; k++) begin
            use64 = (k == 1);
            #1;
            check($sformatf("reset ready/valid x%0d", k), {req_ready, rsp_valid, rsp_err}, 3'b100);
            check($sformatf("reset strobes x%0d", k), {rstrb, wstrb}, 2'b00);
            check($sformatf("reset mem fields x%0d", k), {mem_addr, mem_mask}, 40'h0);
            check($sformatf("reset rsp data x%0d", k), rsp_data, 64'h0);
        end
        #20 rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i]);

        // Reset while WAIT is stalled on a busy read; busy is high during
        // ISSUE too, which must not delay leaving ISSUE.
        @(posedge clk); #1;
        use64 = 1'b0; req_load = 1'b1; req_f3 = 3'd2; req_addr = 32'h8;
        req_rd = 5'd30; rdata = 64'h12345678; rbusy = 1'b1; rsp_ready = 1'b1; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        check("rst seq issue strobe", {rstrb, wstrb}, 2'b10);
        @(negedge clk);
        check("rst seq wait addr held", mem_addr, 32'h8);
        check("rst seq wait no rsp", {rsp_valid, req_ready}, 2'b00);
        #2 rst_n = 1'b0;
        #1;
        check("async rst strobes", {rstrb, wstrb}, 2'b00);
        check("async rst valid/ready", {rsp_valid, req_ready}, 2'b01);
        check("async rst mem fields", {mem_addr, mem_mask}, 40'h0);
        @(negedge clk);
        rbusy = 1'b0;
        rst_n = 1'b1;
        run_vec(vecs[6]);
        run_vec(vecs[3]);

        check("scoreboard drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
